// File: rtl/fft_stream_ctrl_pkg.sv
// Shared definitions for the FFT streaming sequencer: controller state encoding
// and the result latency of the FFT core model that runs alongside it.
package fft_stream_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   // Clock-enabled cycles between a sample entering the FFT core model and its result.
   localparam int FFT_LATENCY = 40;

endpackage

// File: rtl/fft_stream_ctrl.sv
// Streaming sequencer around a pipelined FFT core: gates the core clock enable
// on input/output handshakes, hides pre-sync garbage, and drains with zero pads.
module fft_stream_ctrl
   import fft_stream_ctrl_pkg::*;
#(
   parameter int IW     = 15,
   parameter int OW     = 21,
   parameter int LGSIZE = 11,
   parameter int FCW    = 3
) (
   input  logic              i_clk,
   input  logic              i_areset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [2*IW-1:0]   s_data,
   input  logic              s_last,
   input  logic              i_flush,
   output logic              o_fft_reset,
   output logic              o_fft_ce,
   output logic [2*IW-1:0]   o_fft_sample,
   input  logic [2*OW-1:0]   i_fft_result,
   input  logic              i_fft_sync,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [2*OW-1:0]   m_data,
   output logic              m_last,
   output logic              o_busy,
   output logic              o_err,
   output state_e            o_dbg_state
);

   localparam logic [LGSIZE-1:0] IDX_LAST = '1;
   localparam logic [LGSIZE-1:0] IDX_ONE  = LGSIZE'(1);
   localparam logic [FCW-1:0]    FCNT_MAX = '1;

   state_e            state_q, state_d;
   logic [LGSIZE-1:0] iidx_q, iidx_d;
   logic [LGSIZE-1:0] oidx_q, oidx_d;
   logic [FCW-1:0]    fcnt_q, fcnt_d;
   logic              pend_q, pend_d;
   logic              primed_q, primed_d;
   logic              real_q, real_d;
   logic              err_q, err_d;

   logic              out_ok;
   logic              ce;
   logic              s_fire;
   logic              m_fire;
   logic              frame_inc;
   logic              frame_dec;

   // Both sides use strict valid/ready: a beat transfers exactly on a cycle where
   // valid && ready; a raised valid and its data hold until that transfer happens.
   always_comb begin
      m_valid      = pend_q && (primed_q || i_fft_sync);
      out_ok       = !m_valid || m_ready;
      s_ready      = (state_q == ST_RUN) && out_ok &&
                     !(iidx_q == '0 && fcnt_q == FCNT_MAX);
      s_fire       = s_valid && s_ready;
      m_fire       = m_valid && m_ready;
      m_last       = m_valid && (oidx_q == IDX_LAST);
      m_data       = i_fft_result;
      o_fft_sample = (state_q == ST_RUN) ? s_data : '0;
      o_fft_reset  = (state_q == ST_CLEAR);
      o_busy       = (state_q != ST_IDLE);
      o_err        = err_q;
      o_dbg_state  = state_q;
      ce           = 1'b0;
      case (state_q)
         ST_RUN:   ce = s_fire;
         ST_FLUSH: ce = out_ok && (iidx_q != '0 || fcnt_q != '0);
         default:  ce = 1'b0;
      endcase
      o_fft_ce     = ce;
      // A frame counts as in flight only if at least one real sample went into it.
      frame_inc    = ce && (iidx_q == IDX_LAST) && (real_q || state_q == ST_RUN);
      frame_dec    = m_fire && (oidx_q == IDX_LAST);
   end

   always_comb begin
      state_d  = state_q;
      iidx_d   = iidx_q;
      oidx_d   = oidx_q;
      fcnt_d   = fcnt_q;
      pend_d   = pend_q;
      primed_d = primed_q;
      real_d   = real_q;
      err_d    = err_q
               | (s_fire && s_last && iidx_q != IDX_LAST)
               | (pend_q && i_fft_sync && oidx_q != '0);

      case (state_q)
         ST_CLEAR: state_d = ST_IDLE;
         ST_IDLE:  if (s_valid) state_d = ST_RUN;
         ST_RUN:   if (i_flush) state_d = ST_FLUSH;
         ST_FLUSH: if (fcnt_q == '0 && iidx_q == '0) state_d = ST_CLEAR;
         default:  state_d = ST_CLEAR;
      endcase

      if (state_q == ST_CLEAR) begin
         iidx_d   = '0;
         oidx_d   = '0;
         fcnt_d   = '0;
         pend_d   = 1'b0;
         primed_d = 1'b0;
         real_d   = 1'b0;
      end else begin
         if (ce) begin
            iidx_d = iidx_q + IDX_ONE;
         end
         if (ce && iidx_q == IDX_LAST) begin
            real_d = 1'b0;
         end else if (ce && state_q == ST_RUN) begin
            real_d = 1'b1;
         end
         // A pre-prime result is simply overwritten: the next ce re-arms pend.
         if (ce) begin
            pend_d = 1'b1;
         end else if (m_fire) begin
            pend_d = 1'b0;
         end
         if (pend_q && i_fft_sync) begin
            primed_d = 1'b1;
         end
         if (m_fire) begin
            oidx_d = oidx_q + IDX_ONE;
         end
         fcnt_d = fcnt_q + {{(FCW-1){1'b0}}, frame_inc} - {{(FCW-1){1'b0}}, frame_dec};
      end
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state_q  <= ST_CLEAR;
         iidx_q   <= '0;
         oidx_q   <= '0;
         fcnt_q   <= '0;
         pend_q   <= 1'b0;
         primed_q <= 1'b0;
         real_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         iidx_q   <= iidx_d;
         oidx_q   <= oidx_d;
         fcnt_q   <= fcnt_d;
         pend_q   <= pend_d;
         primed_q <= primed_d;
         real_q   <= real_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl: drives it next to a small FFT core model (delay line
// with sync and pre-sync garbage) and scores every output beat against sent data.
module tb_fft_stream_ctrl;
   import fft_stream_ctrl_pkg::*;

   localparam int IW     = 15;
   localparam int OW     = 21;
   localparam int LGSIZE = 11;
   localparam int FCW    = 3;
   localparam int N      = 1 << LGSIZE;
   localparam int LAT    = FFT_LATENCY;
   localparam logic [2*IW-1:0] IMP = 30'h1000_0000;

   logic              i_clk;
   logic              i_areset_n;
   logic              s_valid;
   logic              s_ready;
   logic [2*IW-1:0]   s_data;
   logic              s_last;
   logic              i_flush;
   logic              o_fft_reset;
   logic              o_fft_ce;
   logic [2*IW-1:0]   o_fft_sample;
   logic [2*OW-1:0]   i_fft_result;
   logic              i_fft_sync;
   logic              m_valid;
   logic              m_ready;
   logic [2*OW-1:0]   m_data;
   logic              m_last;
   logic              o_busy;
   logic              o_err;
   state_e            o_dbg_state;

   int n_assert;
   int n_fail;
   int cyc;
   int rdy_mode;

   logic [2*IW-1:0] exp_q[$];
   int beat_n;
   int last_n;
   int pad_n;
   int sent_n;
   bit flushing;
   bit err_exp;

   fft_stream_ctrl #(.IW(IW), .OW(OW), .LGSIZE(LGSIZE), .FCW(FCW)) dut (
      .i_clk        (i_clk),
      .i_areset_n   (i_areset_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .i_flush      (i_flush),
      .o_fft_reset  (o_fft_reset),
      .o_fft_ce     (o_fft_ce),
      .o_fft_sample (o_fft_sample),
      .i_fft_result (i_fft_result),
      .i_fft_sync   (i_fft_sync),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .o_busy       (o_busy),
      .o_err        (o_err),
      .o_dbg_state  (o_dbg_state)
   );

   // ---------------- clock ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- FFT core model ----------------
   function automatic logic [2*OW-1:0] widen(input logic [2*IW-1:0] s);
      return {{(OW-IW){s[2*IW-1]}}, s[2*IW-1:IW], {(OW-IW){s[IW-1]}}, s[IW-1:0]};
   endfunction

   logic [2*IW-1:0] core_pipe [LAT];
   int core_fill;
   int core_out_n;

   always @(posedge i_clk) begin
      if (o_fft_reset) begin
         core_fill    <= 0;
         core_out_n   <= 0;
         i_fft_result <= '0;
         i_fft_sync   <= 1'b0;
      end else if (o_fft_ce) begin
         core_pipe[0] <= o_fft_sample;
         for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
         if (core_fill >= LAT) begin
            i_fft_result <= widen(core_pipe[LAT-1]);
            i_fft_sync   <= ((core_out_n % N) == 0);
            core_out_n   <= core_out_n + 1;
         end else begin
            i_fft_result <= (2*OW)'({$urandom, $urandom});
            i_fft_sync   <= 1'b0;
            core_fill    <= core_fill + 1;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_reset();
      exp_q.delete();
      beat_n = 0;
      last_n = 0;
      pad_n  = 0;
      sent_n = 0;
   endtask

   // Output scoreboard and back-pressure checks, sampled on the falling edge.
   initial begin : monitor
      bit stall_q;
      logic [2*OW-1:0] stall_data;
      stall_q    = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge i_clk);
         if (!i_areset_n) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               chk("stall_valid", 64'(m_valid), 64'(1));
               chk("stall_data", 64'(m_data), 64'(stall_data));
            end
            stall_q    = m_valid && !m_ready;
            stall_data = m_data;
            if (stall_q) chk("ce_frozen", 64'(o_fft_ce), 64'(0));
            if (m_valid && m_ready) begin
               if (beat_n == 0) chk("first_sync", 64'(i_fft_sync), 64'(1));
               if (exp_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
               else chk("m_data", 64'(m_data), 64'(widen(exp_q.pop_front())));
               chk("m_last", 64'(m_last), 64'((beat_n % N) == N - 1));
               if (m_last) last_n++;
               beat_n++;
            end
            if (flushing && o_fft_ce) begin
               chk("pad_zero", 64'(o_fft_sample), 64'(0));
               exp_q.push_back('0);
               pad_n++;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
      cyc++;
      case (rdy_mode)
         1:       m_ready = (cyc % 3) != 0;
         2:       m_ready = ($urandom_range(0, 3) != 0);
         default: m_ready = 1'b1;
      endcase
   endtask

   task automatic send(input logic [2*IW-1:0] d, input logic last, input bit gaps);
      int guard;
      bit fired;
      if (gaps) while ($urandom_range(0, 7) == 0) tick();
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      guard   = 0;
      fired   = 1'b0;
      while (!fired && guard < 64) begin
         @(negedge i_clk);
         fired = s_ready;
         if (fired) begin
            chk("ce_on_accept", 64'(o_fft_ce), 64'(1));
            chk("fft_sample", 64'(o_fft_sample), 64'(d));
            exp_q.push_back(d);
            if (last && (sent_n % N) != N - 1) err_exp = 1'b1;
            sent_n++;
         end
         tick();
         guard++;
      end
      if (!fired) chk("s_ready_timeout", 64'(0), 64'(1));
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic stream_impulse(input bit gaps);
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < N; j++)
            send((j == k) ? IMP : '0, j == N - 1, gaps);
   endtask

   // Pads run to the end of the partial frame, then whole pad frames until the
   // last real frame has drained out of the core's LAT-deep pipeline.
   task automatic do_flush(input int s_total);
      int frames;
      int pads_exp;
      int g;
      bit done;
      frames   = (s_total + N - 1) / N;
      pads_exp = (frames + (LAT + N - 1) / N) * N - s_total;
      flushing = 1'b1;
      i_flush  = 1'b1;
      done     = 1'b0;
      g        = 0;
      while (!done && g < 40000) begin
         @(negedge i_clk);
         done = o_fft_reset;
         tick();
         g++;
      end
      flushing = 1'b0;
      i_flush  = 1'b0;
      chk("flush_done", 64'(done), 64'(1));
      chk("pad_count", 64'(pad_n), 64'(pads_exp));
      chk("frames_out", 64'(last_n), 64'(frames));
      chk("sent_count", 64'(sent_n), 64'(s_total));
      @(negedge i_clk);
      chk("pulse_1cyc", 64'(o_fft_reset), 64'(0));
      chk("idle_after", 64'(o_dbg_state), 64'(ST_IDLE));
      chk("busy_after", 64'(o_busy), 64'(0));
      chk("mvalid_after", 64'(m_valid), 64'(0));
      chk("err_after", 64'(o_err), 64'(err_exp));
      tick();
      sb_reset();
   endtask

   task automatic release_reset();
      @(posedge i_clk);
      #1;
      i_areset_n = 1'b1;
      @(negedge i_clk);
      chk("pulse_hi", 64'(o_fft_reset), 64'(1));
      chk("clear_state", 64'(o_dbg_state), 64'(ST_CLEAR));
      tick();
      @(negedge i_clk);
      chk("pulse_lo", 64'(o_fft_reset), 64'(0));
      chk("idle_state", 64'(o_dbg_state), 64'(ST_IDLE));
      chk("idle_busy", 64'(o_busy), 64'(0));
      chk("idle_mvalid", 64'(m_valid), 64'(0));
      chk("idle_sready", 64'(s_ready), 64'(0));
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_fft_reset"}, 64'(o_fft_reset), 64'(1));
      chk({tag, "_s_ready"}, 64'(s_ready), 64'(0));
      chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
      chk({tag, "_m_last"}, 64'(m_last), 64'(0));
      chk({tag, "_ce"}, 64'(o_fft_ce), 64'(0));
      chk({tag, "_err"}, 64'(o_err), 64'(0));
      chk({tag, "_busy"}, 64'(o_busy), 64'(1));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_assert   = 0;
      n_fail     = 0;
      cyc        = 0;
      rdy_mode   = 0;
      flushing   = 1'b0;
      err_exp    = 1'b0;
      i_areset_n = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      i_flush    = 1'b0;
      m_ready    = 1'b1;
      sb_reset();

      repeat (3) @(posedge i_clk);
      #1;
      chk_reset_outputs("rst");
      release_reset();

      // Impulse frames, downstream always ready.
      rdy_mode = 0;
      stream_impulse(1'b0);
      do_flush(3 * N);

      // Same frames with downstream stalling one cycle in three, plus input gaps.
      rdy_mode = 1;
      stream_impulse(1'b1);
      do_flush(3 * N);

      // One frame and a partial frame, flushed mid-frame.
      rdy_mode = 2;
      for (int i = 0; i < N + 100; i++) send((2*IW)'($urandom), 1'b0, 1'b1);
      do_flush(N + 100);

      // Misplaced end-of-frame marker sets the sticky error without disturbing data.
      for (int i = 0; i < N; i++) begin
         send((2*IW)'($urandom), i == 1000, 1'b1);
         if (i == 999) chk("err_before", 64'(o_err), 64'(0));
         if (i == 1002) chk("err_set", 64'(o_err), 64'(err_exp));
      end
      do_flush(N);
      chk("err_sticky", 64'(o_err), 64'(1));

      // Asynchronous reset in the middle of the second frame, then a clean restart.
      rdy_mode = 0;
      for (int i = 0; i < N + 500; i++) send((i == N + 1) ? IMP : (2*IW)'($urandom), 1'b0, 1'b0);
      s_valid = 1'b1;
      s_data  = IMP;
      #2;
      i_areset_n = 1'b0;
      #1;
      chk_reset_outputs("async");
      s_valid = 1'b0;
      err_exp = 1'b0;
      repeat (3) @(posedge i_clk);
      sb_reset();
      release_reset();
      stream_impulse(1'b0);
      do_flush(3 * N);
      chk("err_final", 64'(o_err), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
